// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM multi-port arbiter.
// Requester index 2i is write port i; index 2i+1 is read port i.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int IDX_W     = 4;

    function automatic logic [2:0] req_port(input logic [IDX_W-1:0] idx);
        return idx[3:1];
    endfunction

    function automatic logic req_is_rd(input logic [IDX_W-1:0] idx);
        return idx[0];
    endfunction

    function automatic logic [IDX_W-1:0] req_next(input logic [IDX_W-1:0] idx, input int num_req);
        if (int'(idx) + 1 >= num_req)
            return '0;
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational selector: round robin from ptr upward (wrapping), or lowest
// set index when fixed priority is selected.
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    logic [IDX_W-1:0] start;

    always_comb begin
        start = (ARB_MODE == ARB_FIXED) ? '0 : ptr;
        idx   = '0;
        vld   = 1'b0;
        // Two passes avoid a dynamic modulo index: first [start..N-1], then [0..start-1].
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!vld && req[i] && (i >= int'(start))) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!vld && req[i] && (i < int'(start))) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port front end: grants one write/read requester per burst onto the
// single SDRAM controller interface and steers ack/data back to it.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 10,
    parameter int ARB_MODE  = 0,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init_done,
    input  logic [NUM_PORTS-1:0]        p_wr_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_wr_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  p_wr_len,
    input  logic [NUM_PORTS*DATA_W-1:0] p_din,
    output logic [NUM_PORTS-1:0]        p_wr_ack,
    input  logic [NUM_PORTS-1:0]        p_rd_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_rd_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  p_rd_len,
    output logic [NUM_PORTS-1:0]        p_rd_ack,
    output logic [DATA_W-1:0]           p_dout,
    output logic                        c_wr_req,
    output logic                        c_rd_req,
    input  logic                        c_wr_ack,
    input  logic                        c_rd_ack,
    output logic [ADDR_W-1:0]           c_wr_addr,
    output logic [ADDR_W-1:0]           c_rd_addr,
    output logic [LEN_W-1:0]            c_wr_burst,
    output logic [LEN_W-1:0]            c_rd_burst,
    output logic [DATA_W-1:0]           c_din,
    input  logic [DATA_W-1:0]           c_dout,
    output logic [3:0]                  grant_id,
    output logic                        busy,
    output logic                        err_timeout
);

    localparam int NUM_REQ = 2 * NUM_PORTS;

    arb_state_t       state, state_n;
    logic [NUM_REQ-1:0] req_vec;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [IDX_W-1:0] rr_ptr;
    logic             g_rd;
    logic [2:0]       g_port;
    logic [2:0]       pick_port;
    logic [31:0]      wd_cnt;
    logic             wd_expire;
    logic             ack_match;
    logic             do_grant;
    logic             do_ack;
    logic             do_timeout;
    logic             do_done;
    logic [ADDR_W-1:0] pick_wr_addr;
    logic [ADDR_W-1:0] pick_rd_addr;
    logic [LEN_W-1:0]  pick_wr_len;
    logic [LEN_W-1:0]  pick_rd_len;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_vec[2*i]   = p_wr_req[i];
            req_vec[2*i+1] = p_rd_req[i];
        end
    end

    sdram_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .req (req_vec),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    assign pick_port = req_port(pick_idx);
    assign g_port    = req_port(grant_id);

    always_comb begin
        pick_wr_addr = '0;
        pick_rd_addr = '0;
        pick_wr_len  = '0;
        pick_rd_len  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_port == 3'(i)) begin
                pick_wr_addr = p_wr_addr[i*ADDR_W +: ADDR_W];
                pick_rd_addr = p_rd_addr[i*ADDR_W +: ADDR_W];
                pick_wr_len  = p_wr_len[i*LEN_W +: LEN_W];
                pick_rd_len  = p_rd_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Only the ack matching the granted type counts; the other channel is ignored.
    assign ack_match = g_rd ? c_rd_ack : c_wr_ack;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        do_grant   = 1'b0;
        do_ack     = 1'b0;
        do_timeout = 1'b0;
        do_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_done && pick_vld) begin
                    do_grant = 1'b1;
                    state_n  = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_match) begin
                    do_ack  = 1'b1;
                    state_n = S_XFER;
                end else if (wd_expire) begin
                    do_timeout = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            S_XFER: begin
                if (!ack_match) begin
                    do_done = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id    <= '0;
            g_rd        <= 1'b0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            c_wr_req    <= 1'b0;
            c_rd_req    <= 1'b0;
            c_wr_addr   <= '0;
            c_rd_addr   <= '0;
            c_wr_burst  <= '0;
            c_rd_burst  <= '0;
        end else begin
            err_timeout <= 1'b0;
            if (state == S_REQ)
                wd_cnt <= wd_cnt + 32'd1;
            if (do_grant) begin
                grant_id <= pick_idx;
                g_rd     <= req_is_rd(pick_idx);
                busy     <= 1'b1;
                wd_cnt   <= '0;
                if (req_is_rd(pick_idx)) begin
                    c_rd_req   <= 1'b1;
                    c_rd_addr  <= pick_rd_addr;
                    c_rd_burst <= pick_rd_len;
                end else begin
                    c_wr_req   <= 1'b1;
                    c_wr_addr  <= pick_wr_addr;
                    c_wr_burst <= pick_wr_len;
                end
            end
            if (do_ack) begin
                c_wr_req <= 1'b0;
                c_rd_req <= 1'b0;
            end
            // Both burst end and watchdog expiry release the grant and move the pointer past it.
            if (do_timeout || do_done) begin
                c_wr_req    <= 1'b0;
                c_rd_req    <= 1'b0;
                c_wr_addr   <= '0;
                c_rd_addr   <= '0;
                c_wr_burst  <= '0;
                c_rd_burst  <= '0;
                busy        <= 1'b0;
                rr_ptr      <= req_next(grant_id, NUM_REQ);
                err_timeout <= do_timeout;
            end
        end
    end

    always_comb begin
        p_wr_ack = '0;
        p_rd_ack = '0;
        c_din    = '0;
        if (state == S_XFER) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (g_port == 3'(i)) begin
                    if (g_rd) begin
                        p_rd_ack[i] = c_rd_ack;
                    end else begin
                        p_wr_ack[i] = c_wr_ack;
                        c_din       = p_din[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    assign p_dout = c_dout;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: round-robin instance and fixed-priority instance share stimulus;
// sel_fx chooses which instance's outputs the checks observe.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int LW = 10;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
    logic [NP-1:0]    p_wr_req, p_rd_req;
    logic [NP*AW-1:0] p_wr_addr, p_rd_addr;
    logic [NP*LW-1:0] p_wr_len, p_rd_len;
    logic [NP*DW-1:0] p_din;
    logic             c_wr_ack, c_rd_ack;
    logic [DW-1:0]    c_dout;
    logic             sel_fx;

    logic [NP-1:0] rr_wr_ack, rr_rd_ack, fx_wr_ack, fx_rd_ack;
    logic [DW-1:0] rr_dout, fx_dout, rr_din, fx_din;
    logic          rr_wr_req, rr_rd_req, fx_wr_req, fx_rd_req;
    logic [AW-1:0] rr_wr_addr, rr_rd_addr, fx_wr_addr, fx_rd_addr;
    logic [LW-1:0] rr_wr_burst, rr_rd_burst, fx_wr_burst, fx_rd_burst;
    logic [3:0]    rr_gid, fx_gid;
    logic          rr_busy, fx_busy, rr_err, fx_err;

    logic [NP-1:0] wr_ack_o, rd_ack_o;
    logic [DW-1:0] dout_o, din_o;
    logic          wr_req_o, rd_req_o, busy_o, err_o;
    logic [AW-1:0] wr_addr_o, rd_addr_o;
    logic [LW-1:0] wr_burst_o, rd_burst_o;
    logic [3:0]    gid_o;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
                         .ARB_MODE(0), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst(rst), .init_done(init_done),
        .p_wr_req(p_wr_req), .p_wr_addr(p_wr_addr), .p_wr_len(p_wr_len), .p_din(p_din),
        .p_wr_ack(rr_wr_ack), .p_rd_req(p_rd_req), .p_rd_addr(p_rd_addr), .p_rd_len(p_rd_len),
        .p_rd_ack(rr_rd_ack), .p_dout(rr_dout), .c_wr_req(rr_wr_req), .c_rd_req(rr_rd_req),
        .c_wr_ack(c_wr_ack), .c_rd_ack(c_rd_ack), .c_wr_addr(rr_wr_addr), .c_rd_addr(rr_rd_addr),
        .c_wr_burst(rr_wr_burst), .c_rd_burst(rr_rd_burst), .c_din(rr_din), .c_dout(c_dout),
        .grant_id(rr_gid), .busy(rr_busy), .err_timeout(rr_err)
    );

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
                         .ARB_MODE(1), .TIMEOUT(TO)) u_fx (
        .clk(clk), .rst(rst), .init_done(init_done),
        .p_wr_req(p_wr_req), .p_wr_addr(p_wr_addr), .p_wr_len(p_wr_len), .p_din(p_din),
        .p_wr_ack(fx_wr_ack), .p_rd_req(p_rd_req), .p_rd_addr(p_rd_addr), .p_rd_len(p_rd_len),
        .p_rd_ack(fx_rd_ack), .p_dout(fx_dout), .c_wr_req(fx_wr_req), .c_rd_req(fx_rd_req),
        .c_wr_ack(c_wr_ack), .c_rd_ack(c_rd_ack), .c_wr_addr(fx_wr_addr), .c_rd_addr(fx_rd_addr),
        .c_wr_burst(fx_wr_burst), .c_rd_burst(fx_rd_burst), .c_din(fx_din), .c_dout(c_dout),
        .grant_id(fx_gid), .busy(fx_busy), .err_timeout(fx_err)
    );

    always_comb begin
        wr_ack_o   = sel_fx ? fx_wr_ack   : rr_wr_ack;
        rd_ack_o   = sel_fx ? fx_rd_ack   : rr_rd_ack;
        dout_o     = sel_fx ? fx_dout     : rr_dout;
        din_o      = sel_fx ? fx_din      : rr_din;
        wr_req_o   = sel_fx ? fx_wr_req   : rr_wr_req;
        rd_req_o   = sel_fx ? fx_rd_req   : rr_rd_req;
        wr_addr_o  = sel_fx ? fx_wr_addr  : rr_wr_addr;
        rd_addr_o  = sel_fx ? fx_rd_addr  : rr_rd_addr;
        wr_burst_o = sel_fx ? fx_wr_burst : rr_wr_burst;
        rd_burst_o = sel_fx ? fx_rd_burst : rr_rd_burst;
        gid_o      = sel_fx ? fx_gid      : rr_gid;
        busy_o     = sel_fx ? fx_busy     : rr_busy;
        err_o      = sel_fx ? fx_err      : rr_err;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Acts as the controller for one burst of requester id and checks routing.
    task automatic burst(input logic [3:0] id, input int hold);
        int n;
        logic rd;
        logic [2:0] pt;
        rd = id[0];
        pt = id[3:1];
        n  = 0;
        while (!(wr_req_o || rd_req_o) && n < 40) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(n < 40), 1);
        chk("grant_id", 32'(gid_o), 32'(id));
        chk("busy_set", 32'(busy_o), 1);
        chk("req_type", {wr_req_o, rd_req_o}, rd ? 2'b01 : 2'b10);
        chk("addr", rd ? rd_addr_o : wr_addr_o, rd ? (24'h020000 + pt) : (24'h010000 + pt));
        chk("burst_len", rd ? rd_burst_o : wr_burst_o, rd ? (10'd16 + pt) : (10'd8 + pt));
        chk("unused_addr", rd ? wr_addr_o : rd_addr_o, 0);
        tick();
        if (rd) c_rd_ack = 1'b1;
        else    c_wr_ack = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("req_dropped", {wr_req_o, rd_req_o}, 0);
            chk("wr_ack_route", wr_ack_o, rd ? 4'b0000 : (4'b0001 << pt));
            chk("rd_ack_route", rd_ack_o, rd ? (4'b0001 << pt) : 4'b0000);
            if (!rd) chk("c_din_mux", din_o, 16'hD000 + pt);
        end
        c_wr_ack = 1'b0;
        c_rd_ack = 1'b0;
        tick();
        chk("busy_clear", 32'(busy_o), 0);
        chk("acks_clear", {wr_ack_o, rd_ack_o}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int cnt;
        rst       = 1'b1;
        init_done = 1'b0;
        sel_fx    = 1'b0;
        p_wr_req  = '0;
        p_rd_req  = '0;
        c_wr_ack  = 1'b0;
        c_rd_ack  = 1'b0;
        c_dout    = 16'hBEEF;
        for (int i = 0; i < NP; i++) begin
            p_wr_addr[i*AW +: AW] = 24'h010000 + 24'(i);
            p_rd_addr[i*AW +: AW] = 24'h020000 + 24'(i);
            p_wr_len[i*LW +: LW]  = 10'd8 + 10'(i);
            p_rd_len[i*LW +: LW]  = 10'd16 + 10'(i);
            p_din[i*DW +: DW]     = 16'hD000 + 16'(i);
        end
        tick();
        tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_gid", 32'(gid_o), 0);
        chk("rst_reqs", {wr_req_o, rd_req_o}, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_addr", wr_addr_o | rd_addr_o, 0);
        chk("rst_acks", {wr_ack_o, rd_ack_o}, 0);
        chk("dout_pass", 32'(dout_o), 32'h0000BEEF);
        rst = 1'b0;
        tick();

        // Round robin over all eight requesters, wrapping back to 0.
        init_done = 1'b1;
        p_wr_req  = '1;
        p_rd_req  = '1;
        for (int g = 0; g < 9; g++) burst(4'(g % 8), 8);
        p_wr_req = '0;
        p_rd_req = '0;

        // Single write port 2 with custom address/length; pointer is 1 so 4 wins.
        p_wr_addr[2*AW +: AW] = 24'h000400;
        p_wr_len[2*LW +: LW]  = 10'd256;
        p_wr_req[2] = 1'b1;
        tick();
        chk("t2_req_next_cycle", 32'(wr_req_o), 1);
        chk("t2_gid", 32'(gid_o), 4);
        chk("t2_addr", 32'(wr_addr_o), 32'h000400);
        chk("t2_burst", 32'(wr_burst_o), 256);
        chk("t2_rd_idle", 32'(rd_req_o), 0);
        p_wr_req[2] = 1'b0;
        tick();
        chk("t2_no_abort", 32'(wr_req_o), 1);
        c_wr_ack = 1'b1;
        tick();
        chk("t2_ack_route", wr_ack_o, 4'b0100);
        chk("t2_din", 32'(din_o), 32'hD002);
        p_din[2*DW +: DW] = 16'h1234;
        #1;
        chk("t2_din_track", 32'(din_o), 32'h1234);
        c_wr_ack = 1'b0;
        tick();
        chk("t2_busy_clear", 32'(busy_o), 0);
        p_din[2*DW +: DW]     = 16'hD002;
        p_wr_addr[2*AW +: AW] = 24'h010002;
        p_wr_len[2*LW +: LW]  = 10'd10;

        // Watchdog: read port 1 (requester 3) never acked.
        p_rd_req[1] = 1'b1;
        n = 0;
        while (!rd_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("t4_req_seen", 32'(n < 10), 1);
        chk("t4_gid", 32'(gid_o), 3);
        cnt = 0;
        while (rd_req_o && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("t4_req_cycles", cnt, TO);
        chk("t4_err_pulse", 32'(err_o), 1);
        chk("t4_busy_clear", 32'(busy_o), 0);
        p_rd_req[1] = 1'b0;
        tick();
        chk("t4_err_once", 32'(err_o), 0);
        p_wr_req[1] = 1'b1;
        p_rd_req[2] = 1'b1;
        burst(4'd5, 2);
        p_wr_req[1] = 1'b0;
        p_rd_req[2] = 1'b0;

        // init_done low blocks grants; a spurious ack while idle is not forwarded.
        init_done   = 1'b0;
        p_wr_req[0] = 1'b1;
        c_wr_ack    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_no_req", {wr_req_o, rd_req_o}, 0);
            chk("t5_spurious_ack", wr_ack_o, 0);
        end
        c_wr_ack  = 1'b0;
        init_done = 1'b1;
        n = 0;
        while (!wr_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("t5_grant_latency", 32'(n <= 2), 1);
        burst(4'd0, 3);
        p_wr_req[0] = 1'b0;

        // Asynchronous reset mid-transfer of requester 6.
        p_wr_req[3] = 1'b1;
        tick();
        chk("t6_gid", 32'(gid_o), 6);
        tick();
        c_wr_ack = 1'b1;
        tick();
        chk("t6_in_xfer", wr_ack_o, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_busy", 32'(busy_o), 0);
        chk("t6_async_gid", 32'(gid_o), 0);
        chk("t6_async_ack", wr_ack_o, 0);
        chk("t6_async_addr", wr_addr_o | 24'(wr_burst_o), 0);
        p_wr_req[3] = 1'b0;
        c_wr_ack    = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        tick();
        chk("t6_idle", {busy_o, wr_req_o, rd_req_o}, 0);
        p_wr_req[0] = 1'b1;
        p_wr_req[3] = 1'b1;
        burst(4'd0, 2);
        p_wr_req[0] = 1'b0;
        p_wr_req[3] = 1'b0;

        // Fixed priority: requesters 3 and 5 both pending, 3 always wins.
        rst    = 1'b1;
        sel_fx = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        p_rd_req[1] = 1'b1;
        p_rd_req[2] = 1'b1;
        for (int k = 0; k < 3; k++) burst(4'd3, 2);
        p_rd_req[1] = 1'b0;
        p_rd_req[2] = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
